serial_add_sub_controller: RTL and testbench

Bit-serial N-bit adder/subtractor sequencer. Latches two WIDTH-bit operands and a mode bit, then drives a single `one_bit_adder_subtractor` slice one bit per clock, LSB first, through an internal carry flip-flop. It sits between a requester using a start/done handshake and the one-bit slice, trading WIDTH cycles of latency for one slice of hardware.

---
 rtl/serial_add_sub_controller.sv | 139 +++++++++++++
 tb/tb_serial_add_sub_controller.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/serial_add_sub_controller.sv
// ============================================================================
// Module   : serial_add_sub_controller (+ one_bit_adder_subtractor slice)
// Brief    : Bit-serial WIDTH-bit add/sub sequencer, LSB first, one slice.
//            Define SERIAL_ADDSUB_OVF_EN to compile the signed-overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module one_bit_adder_subtractor (
  input  logic a_i,
  input  logic b_i,
  input  logic sel_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);

  logic bx_w;

  assign bx_w   = b_i ^ sel_i;
  assign s_o    = a_i ^ bx_w ^ cin_i;
  assign cout_o = (a_i & bx_w) | (cin_i & (a_i ^ bx_w));

endmodule

module serial_add_sub_controller #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             sel_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  logic [WIDTH-1:0] result_q;
  logic [CW-1:0]    cnt_q;
  logic             sel_q;
  logic             carry_q;
  logic             cout_q;
  logic             s_w;
  logic             c_w;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic             ovf_q;
`endif

  one_bit_adder_subtractor u_slice (
    .a_i    (a_sr_q[0]),
    .b_i    (b_sr_q[0]),
    .sel_i  (sel_q),
    .cin_i  (carry_q),
    .s_o    (s_w),
    .cout_o (c_w)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      sel_q    <= 1'b0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            a_sr_q   <= a_i;
            b_sr_q   <= b_i;
            sel_q    <= sel_i;
            // Initial carry of 1 supplies the +1 of A + ~B + 1.
            carry_q  <= sel_i;
            cnt_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf_q    <= 1'b0;
`endif
            state_q  <= RUN;
          end else begin
            state_q  <= IDLE;
          end
        end
        RUN: begin
          result_q <= {s_w, result_q[WIDTH-1:1]};
          a_sr_q   <= {1'b0, a_sr_q[WIDTH-1:1]};
          b_sr_q   <= {1'b0, b_sr_q[WIDTH-1:1]};
          carry_q  <= c_w;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == C_LAST) begin
            cout_q  <= c_w;
`ifdef SERIAL_ADDSUB_OVF_EN
            // Carry into MSB differs from carry out of MSB.
            ovf_q   <= carry_q ^ c_w;
`endif
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o   = (state_q == RUN);
  assign done_o   = (state_q == DONE);
  assign result_o = result_q;
  assign cout_o   = cout_q;
`ifdef SERIAL_ADDSUB_OVF_EN
  assign ovf_o    = ovf_q;
`else
  assign ovf_o    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_add_sub_controller.sv
// ============================================================================
// Module   : tb_serial_add_sub_controller
// Brief    : Vector table, reset, back-to-back and random checks vs. a model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_add_sub_controller;

  localparam int W    = 4;
  localparam int NB2B = 20;
`ifdef SERIAL_ADDSUB_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic         clk     = 1'b0;
  logic         rst_n   = 1'b0;
  logic         start_i = 1'b0;
  logic         sel_i   = 1'b0;
  logic [W-1:0] a_i     = '0;
  logic [W-1:0] b_i     = '0;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] result_o;
  logic         cout_o;
  logic         ovf_o;

  int n_tests = 0;
  int n_fail  = 0;

  serial_add_sub_controller #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .sel_i    (sel_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o),
    .cout_o   (cout_o),
    .ovf_o    (ovf_o)
  );

  always #50 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       sel;
    logic [3:0] r;
    logic       c;
    logic       o;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                output logic [W-1:0] r, output logic c, output logic o);
    int unsigned ua, ub, full;
    int sa, sb, tr;
    ua   = a;
    ub   = b;
    full = s ? (ua + ((2 ** W) - 1 - ub) + 1) : (ua + ub);
    r    = W'(full);
    c    = ((full >> W) & 1) != 0;
    sa   = $signed(a);
    sb   = $signed(b);
    tr   = s ? (sa - sb) : (sa + sb);
    o    = OVF_EN && ((tr < -(2 ** (W - 1))) || (tr > (2 ** (W - 1)) - 1));
  endfunction

  // One operation; inputs (and start) are scrambled while RUN to prove they are ignored.
  task automatic run_check(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic s, input logic [W-1:0] er, input logic ec, input logic eo);
    int n;
    int nbusy;
    logic [W-1:0] r;
    @(negedge clk);
    start_i = 1'b1; a_i = a; b_i = b; sel_i = s;
    @(negedge clk);
    n = 0;
    nbusy = 0;
    while (!done_o && n < 4 * W) begin
      if (busy_o) nbusy++;
      a_i = W'($urandom); b_i = W'($urandom); sel_i = 1'($urandom);
      start_i = 1'($urandom);
      @(negedge clk);
      n++;
    end
    start_i = 1'b0;
    chk({name, "_done"}, 32'(done_o), 32'd1);
    chk({name, "_busycycles"}, nbusy, W);
    chk({name, "_result"}, 32'(result_o), 32'(er));
    chk({name, "_cout"}, 32'(cout_o), 32'(ec));
    chk({name, "_ovf"}, 32'(ovf_o), 32'(eo));
    r = result_o;
    @(negedge clk);
    chk({name, "_donepulse"}, 32'(done_o), 32'd0);
    chk({name, "_hold"}, 32'(result_o), 32'(r));
  endtask

  vec_t         vecs[9];
  logic [W-1:0] ba[NB2B * (W + 1)];
  logic [W-1:0] bb[NB2B * (W + 1)];
  logic         bs[NB2B * (W + 1)];

  initial begin
    logic [W-1:0] ra, rb, er;
    logic         rs, ec, eo, saw;

    vecs[0] = '{4'b0101, 4'b0011, 1'b0, 4'b1000, 1'b0, 1'b1};
    vecs[1] = '{4'b0111, 4'b0010, 1'b1, 4'b0101, 1'b1, 1'b0};
    vecs[2] = '{4'b0010, 4'b0011, 1'b1, 4'b1111, 1'b0, 1'b0};
    vecs[3] = '{4'b1000, 4'b0001, 1'b1, 4'b0111, 1'b1, 1'b1};
    vecs[4] = '{4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0};
    vecs[5] = '{4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1};
    vecs[6] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0};
    vecs[7] = '{4'b0000, 4'b0001, 1'b1, 4'b1111, 1'b0, 1'b0};
    vecs[8] = '{4'b0001, 4'b0001, 1'b0, 4'b0010, 1'b0, 1'b0};

    #120;
    chk("reset_busy", 32'(busy_o), 32'd0);
    chk("reset_done", 32'(done_o), 32'd0);
    chk("reset_result", 32'(result_o), 32'd0);
    chk("reset_cout", 32'(cout_o), 32'd0);
    chk("reset_ovf", 32'(ovf_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++)
      run_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sel,
                vecs[i].r, vecs[i].c, vecs[i].o & OVF_EN);

    // Asynchronous reset during the second RUN cycle discards the operation.
    @(negedge clk);
    start_i = 1'b1; a_i = 4'd5; b_i = 4'd3; sel_i = 1'b0;
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    #20 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy_o), 32'd0);
    chk("midrst_done", 32'(done_o), 32'd0);
    chk("midrst_result", 32'(result_o), 32'd0);
    chk("midrst_cout", 32'(cout_o), 32'd0);
    chk("midrst_ovf", 32'(ovf_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 2 * W + 2; i++) begin
      @(negedge clk);
      if (done_o || busy_o) saw = 1'b1;
    end
    chk("midrst_nodone", 32'(saw), 32'd0);
    run_check("after_rst", 4'd1, 4'd1, 1'b0, 4'b0010, 1'b0, 1'b0);

    // start held high with operands changing every cycle.
    @(negedge clk);
    for (int j = 0; j < NB2B * (W + 1); j++) begin
      ba[j] = W'($urandom); bb[j] = W'($urandom); bs[j] = 1'($urandom);
      start_i = 1'b1; a_i = ba[j]; b_i = bb[j]; sel_i = bs[j];
      @(negedge clk);
      chk("b2b_done", 32'(done_o), 32'((j % (W + 1)) == W));
      if ((j % (W + 1)) == W) begin
        model(ba[j - W], bb[j - W], bs[j - W], er, ec, eo);
        chk("b2b_result", 32'(result_o), 32'(er));
        chk("b2b_cout", 32'(cout_o), 32'(ec));
        chk("b2b_ovf", 32'(ovf_o), 32'(eo));
      end
    end
    start_i = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 200; i++) begin
      ra = W'($urandom); rb = W'($urandom); rs = (i >= 100);
      model(ra, rb, rs, er, ec, eo);
      run_check("rand", ra, rb, rs, er, ec, eo);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
